// File: rtl/adder_fu_scheduler.sv
// Round-robin scheduler sharing one external adder FU among NREQ requesters.
// One transaction in flight: IDLE -> ISSUE -> WAIT -> RESP, with a WAIT-state timeout.
module adder_fu_scheduler #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*WIDTH-1:0]  req_a,
  input  logic [NREQ*WIDTH-1:0]  req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        resp_valid,
  output logic [WIDTH-1:0]       resp_data,
  output logic                   resp_err,
  output logic [WIDTH-1:0]       fu_a,
  output logic [WIDTH-1:0]       fu_b,
  output logic                   fu_on_off,
  input  logic [WIDTH-1:0]       fu_c,
  input  logic                   fu_ack,
  output logic                   busy
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [IDXW-1:0]   last_grant;
  logic [IDXW-1:0]   winner;
  logic [IDXW-1:0]   grant_idx;
  logic              grant_found;
  logic [NREQ-1:0]   grant_oh;
  int unsigned       cand;
  logic              xfer;
  logic              timeout_hit;
  logic [TW-1:0]     timer;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [WIDTH-1:0]  result;
  logic              err;

  // Round-robin pick: first valid requester at or after last_grant+1
  always_comb begin
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = (32'(last_grant) + 32'd1 + i) % NREQ;
      if (!grant_found && req_valid[IDXW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IDXW'(cand);
      end
    end
  end

  assign grant_oh    = grant_found ? (NREQ'(1) << grant_idx) : '0;
  assign req_ready   = (state == IDLE && reset) ? grant_oh : '0;
  assign xfer        = |(req_valid & req_ready);
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));
  assign fu_a        = op_a;
  assign fu_b        = op_b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (xfer) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (fu_ack || timeout_hit) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Transaction context: winner, operands, timer and result
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= IDXW'(NREQ - 1);
      winner     <= '0;
      op_a       <= '0;
      op_b       <= '0;
      timer      <= '0;
      result     <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            winner <= grant_idx;
            op_a   <= req_a[32'(grant_idx) * WIDTH +: WIDTH];
            op_b   <= req_b[32'(grant_idx) * WIDTH +: WIDTH];
          end
        end
        ISSUE: timer <= '0;
        WAIT: begin
          if (fu_ack) begin
            result <= fu_c;
            err    <= 1'b0;
          end else if (timeout_hit) begin
            result <= '0;
            err    <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        RESP: last_grant <= winner;
        default: ;
      endcase
    end
  end

  // Registered outputs; the response strobe lands in the cycle after RESP
  always_ff @(posedge clk) begin
    if (!reset) begin
      resp_valid <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      fu_on_off  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      resp_valid <= (state == RESP) ? (NREQ'(1) << winner) : '0;
      resp_data  <= (state == RESP) ? result : '0;
      resp_err   <= (state == RESP) && err;
      fu_on_off  <= (state_next == ISSUE) || (state_next == WAIT);
      busy       <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_adder_fu_scheduler.sv
// Directed bench for adder_fu_scheduler with a behavioural adder FU model.
module tb_adder_fu_scheduler;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned NREQ    = 4;
  localparam int unsigned TIMEOUT = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       resp_valid;
  logic [WIDTH-1:0]      resp_data;
  logic                  resp_err;
  logic [WIDTH-1:0]      fu_a;
  logic [WIDTH-1:0]      fu_b;
  logic                  fu_on_off;
  logic [WIDTH-1:0]      fu_c = '0;
  logic                  fu_ack;
  logic                  busy;

  int   vectors     = 0;
  int   miscompares = 0;
  int   fu_mode     = 0;  // 0: ack next cycle, 1: never ack, 2: manual ack
  logic model_ack   = 1'b0;
  logic man_ack     = 1'b0;

  adder_fu_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .fu_a       (fu_a),
    .fu_b       (fu_b),
    .fu_on_off  (fu_on_off),
    .fu_c       (fu_c),
    .fu_ack     (fu_ack),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  assign fu_ack = (fu_mode == 2) ? man_ack : model_ack;

  // Adder FU: registers the sum and acks one cycle after seeing enable
  always @(posedge clk) begin
    if (fu_mode == 0) begin
      model_ack <= fu_on_off;
      fu_c      <= fu_a + fu_b;
    end else if (fu_mode == 1) begin
      model_ack <= 1'b0;
      fu_c      <= 32'hDEADBEEF;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b);
    req_a[idx*WIDTH +: WIDTH] = a;
    req_b[idx*WIDTH +: WIDTH] = b;
  endtask

  logic [31:0] ta   [4];
  logic [31:0] tb   [4];
  logic [31:0] tsum [4];
  logic [3:0]  expv;
  logic [3:0]  seq  [4];
  int          on_cnt;

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    ta[0] = 32'd10;         tb[0] = 32'd20;         tsum[0] = 32'd30;
    ta[1] = 32'h12345678;   tb[1] = 32'h11111111;   tsum[1] = 32'h23456789;
    ta[2] = 32'd100;        tb[2] = 32'd5;          tsum[2] = 32'd105;
    ta[3] = 32'hAAAA0000;   tb[3] = 32'h00005555;   tsum[3] = 32'hAAAA5555;
    seq[0] = 4'b0001; seq[1] = 4'b0100; seq[2] = 4'b0001; seq[3] = 4'b0100;

    // Reset state
    tick(); tick();
    req_valid = 4'b1111;
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_data", 64'(resp_data), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_fu_on", 64'(fu_on_off), 64'd0);
    chk("rst_fu_a", 64'(fu_a), 64'd0);
    chk("rst_fu_b", 64'(fu_b), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    req_valid = '0;
    tick();
    reset = 1'b1;
    tick();

    // Single request, 1 + 2
    set_req(0, 32'h1, 32'h2);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", 64'(req_ready), 64'h1);
    tick();
    req_valid = '0;
    chk("single_issue_fu_on", 64'(fu_on_off), 64'd1);
    chk("single_issue_fu_a", 64'(fu_a), 64'h1);
    chk("single_issue_fu_b", 64'(fu_b), 64'h2);
    chk("single_issue_busy", 64'(busy), 64'd1);
    chk("single_issue_ready", 64'(req_ready), 64'd0);
    tick();
    chk("single_wait_resp", 64'(resp_valid), 64'd0);
    tick();
    chk("single_resp_state_resp", 64'(resp_valid), 64'd0);
    chk("single_resp_fu_off", 64'(fu_on_off), 64'd0);
    tick();
    chk("single_resp_valid", 64'(resp_valid), 64'h1);
    chk("single_resp_data", 64'(resp_data), 64'h3);
    chk("single_resp_err", 64'(resp_err), 64'd0);
    chk("single_idle_busy", 64'(busy), 64'd0);
    chk("single_fu_a_hold", 64'(fu_a), 64'h1);
    tick();
    chk("single_strobe_end", 64'(resp_valid), 64'd0);

    // All four valid after reset: grants 0,1,2,3 spaced 4 cycles
    reset = 1'b0;
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) set_req(k, ta[k], tb[k]);
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 4; k++) begin
      expv = 4'(1 << k);
      chk("rr_ready", 64'(req_ready), 64'(expv));
      tick();
      req_valid[k] = 1'b0;
      tick(); tick(); tick();
      chk("rr_resp_valid", 64'(resp_valid), 64'(expv));
      chk("rr_resp_data", 64'(resp_data), 64'(tsum[k]));
      chk("rr_resp_err", 64'(resp_err), 64'd0);
    end

    // Carry discarded
    set_req(1, 32'hFFFFFFFF, 32'h1);
    req_valid = 4'b0010;
    #1;
    chk("wrap_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    chk("wrap_resp_valid", 64'(resp_valid), 64'h2);
    chk("wrap_resp_data", 64'(resp_data), 64'h0);
    chk("wrap_resp_err", 64'(resp_err), 64'd0);

    // FU never acks: timeout after 1+TIMEOUT enabled cycles
    fu_mode = 1;
    set_req(2, 32'd5, 32'd6);
    req_valid = 4'b0100;
    #1;
    chk("to_ready", 64'(req_ready), 64'h4);
    tick();
    req_valid = '0;
    on_cnt = 0;
    for (int i = 0; i < 20 && fu_on_off; i++) begin
      on_cnt++;
      tick();
    end
    chk("to_on_cycles", 64'(on_cnt), 64'(1 + TIMEOUT));
    chk("to_resp_state_resp", 64'(resp_valid), 64'd0);
    tick();
    chk("to_resp_valid", 64'(resp_valid), 64'h4);
    chk("to_resp_data", 64'(resp_data), 64'h0);
    chk("to_resp_err", 64'(resp_err), 64'd1);
    fu_mode = 0;
    set_req(3, 32'd7, 32'd8);
    req_valid = 4'b1000;
    #1;
    chk("after_to_ready", 64'(req_ready), 64'h8);
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    chk("after_to_resp_valid", 64'(resp_valid), 64'h8);
    chk("after_to_resp_data", 64'(resp_data), 64'd15);
    chk("after_to_resp_err", 64'(resp_err), 64'd0);

    // req0 and req2 held: grants alternate 0,2,0,2
    set_req(0, 32'd1, 32'd1);
    set_req(2, 32'd3, 32'd4);
    req_valid = 4'b0101;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("alt_ready", 64'(req_ready), 64'(seq[k]));
      tick();
      chk("alt_ready_busy", 64'(req_ready), 64'd0);
      tick(); tick(); tick();
      chk("alt_resp_valid", 64'(resp_valid), 64'(seq[k]));
      chk("alt_resp_data", 64'(resp_data), (seq[k] == 4'b0001) ? 64'd2 : 64'd7);
    end
    req_valid = '0;
    tick();

    // Reset during WAIT, stale ack afterwards
    fu_mode = 1;
    set_req(0, 32'd9, 32'd9);
    req_valid = 4'b0001;
    #1;
    chk("rw_ready", 64'(req_ready), 64'h1);
    tick();
    tick();
    chk("rw_in_wait_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    tick();
    #1;
    chk("rw_resp_valid", 64'(resp_valid), 64'd0);
    chk("rw_resp_data", 64'(resp_data), 64'd0);
    chk("rw_resp_err", 64'(resp_err), 64'd0);
    chk("rw_fu_on", 64'(fu_on_off), 64'd0);
    chk("rw_fu_a", 64'(fu_a), 64'd0);
    chk("rw_fu_b", 64'(fu_b), 64'd0);
    chk("rw_busy", 64'(busy), 64'd0);
    chk("rw_ready_in_reset", 64'(req_ready), 64'd0);
    reset   = 1'b1;
    fu_mode = 2;
    man_ack = 1'b1;
    #1;
    chk("rw_regrant", 64'(req_ready), 64'h1);
    tick();
    fu_mode = 0;
    man_ack = 1'b0;
    req_valid = '0;
    chk("rw_issue_no_resp", 64'(resp_valid), 64'd0);
    tick();
    chk("rw_wait_no_resp", 64'(resp_valid), 64'd0);
    tick();
    tick();
    chk("rw_resp_valid2", 64'(resp_valid), 64'h1);
    chk("rw_resp_data2", 64'(resp_data), 64'd18);
    chk("rw_resp_err2", 64'(resp_err), 64'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/adder_fu_scheduler.md
ADDER_FU_SCHEDULER -- requirements
Module: adder_fu_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter TIMEOUT, default 8, max WAIT cycles before the FU is declared hung.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-007 SHALL have port req_a  input  NREQ*WIDTH  operand a, requester i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port req_b  input  NREQ*WIDTH  operand b, same packing.
REQ-009 SHALL have port req_ready  output  NREQ  one-hot grant; transfer when req_valid[i] && req_ready[i].
REQ-010 SHALL have port resp_valid  output  NREQ  one-hot, one-cycle result strobe to owning requester.
REQ-011 SHALL have port resp_data  output  WIDTH  result; valid only while any resp_valid bit is high.
REQ-012 SHALL have port resp_err  output  1  timeout flag, qualified by resp_valid.
REQ-013 SHALL have port fu_a, fu_b  output  WIDTH  operands to the adder FU.
REQ-014 SHALL have port fu_on_off  output  1  enable to the adder FU.
REQ-015 SHALL have ports fu_c  input  WIDTH  and fu_ack  input  1  adder FU result and acknowledge.
REQ-016 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, one transaction in flight.
REQ-018 IDLE: if any req_valid, SHALL combinationally assert req_ready for exactly one winner, chosen round-robin starting at last_grant+1 (mod NREQ); no req_ready when no req_valid.
REQ-019 On transfer SHALL register winner index, req_a/req_b slices, and go to ISSUE; req_ready SHALL be 0 in all non-IDLE states.
REQ-020 ISSUE (1 cycle): fu_on_off=1, fu_a/fu_b=captured operands, timer cleared; fu_ack in ISSUE SHALL be ignored; go to WAIT.
REQ-021 WAIT: fu_on_off=1, operands held; fu_ack=1 SHALL capture fu_c, clear err, go to RESP.
REQ-022 WAIT without fu_ack: timer increments; at TIMEOUT WAIT cycles without ack SHALL set result=0, err=1, go to RESP.
REQ-023 RESP (1 cycle): resp_valid[winner]=1, resp_data=result, resp_err=err, fu_on_off=0; last_grant<=winner; go to IDLE.
REQ-024 With an FU acking one cycle after enable, resp_valid SHALL rise exactly 3 cycles after the transfer edge; back-to-back transactions SHALL be spaced 4 cycles.
REQ-025 fu_on_off SHALL be 0 in IDLE and RESP; fu_a/fu_b SHALL hold last captured values when off.
REQ-026 Result SHALL be WIDTH bits, carry discarded (modulo 2^WIDTH as returned by the FU); no arithmetic in this block.
REQ-027 A requester SHALL hold req_valid and operands until granted; requests changing while not granted are not latched.
REQ-028 resp_valid has no backpressure; requester SHALL accept in that cycle.

Reset
REQ-029 reset==0 at a rising edge SHALL force IDLE, last_grant=NREQ-1 (requester 0 first), timer=0, result=0, err=0, winner=0, captured operands=0.
REQ-030 During and after reset: req_ready=0 (while reset low), resp_valid=0, resp_data=0, resp_err=0, fu_on_off=0, fu_a=fu_b=0, busy=0.
REQ-031 Reset mid-transaction SHALL abandon it with no resp_valid; a late fu_ack after reset SHALL be ignored.

Verification
REQ-032 Single req0 a=32'h1, b=32'h2, FU model acks next cycle -> req_ready[0] same cycle, resp_valid=4'b0001 3 cycles later, resp_data=32'h3, resp_err=0.
REQ-033 All four req_valid high after reset -> grants in order 0,1,2,3, each resp 4 cycles apart, each resp_data matches its a+b.
REQ-034 a=32'hFFFFFFFF, b=32'h1 -> resp_data=32'h0, resp_err=0.
REQ-035 FU model never acks -> fu_on_off high for 1+TIMEOUT cycles, then resp_valid with resp_data=0, resp_err=1; next request serviced normally.
REQ-036 reset driven low during WAIT, stale fu_ack next cycle -> no resp_valid, all outputs 0, busy=0; after release held request re-granted and completes.
REQ-037 req0 and req2 held continuously valid -> grants alternate 0,2,0,2; req1/req3 never granted.
